// File: rtl/paddle_input_bank.sv
// paddle_input_bank: N-player encoder debounce, quadrature step decode,
// saturating paddle position with live height select, registered bitmap.
module paddle_input_bank #(
   parameter int PLAYERS  = 2,
   parameter int HIST_LEN = 16,
   parameter int ROWS     = 16,
   parameter int PAD_H0   = 3,
   parameter int PAD_H1   = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [PLAYERS-1:0]      enc_a,
   input  logic [PLAYERS-1:0]      enc_b,
   input  logic [PLAYERS-1:0]      width,
   input  logic                    freeze,
   output logic [PLAYERS*ROWS-1:0] paddles,
   output logic [PLAYERS-1:0]      step_evt,
   output logic [PLAYERS-1:0]      step_dir
);

   localparam int PW   = $clog2(ROWS);
   localparam int HW   = $clog2(ROWS + 1);
   localparam int POS0 = (ROWS - PAD_H0) / 2;

   localparam logic [ROWS-1:0] ONES     = '1;
   localparam logic [ROWS-1:0] RST_MASK =
      (ONES >> (ROWS - PAD_H0)) << POS0;

   logic [HIST_LEN-1:0] hist_a_q [PLAYERS];
   logic [HIST_LEN-1:0] hist_a_d [PLAYERS];
   logic [HIST_LEN-1:0] hist_b_q [PLAYERS];
   logic [HIST_LEN-1:0] hist_b_d [PLAYERS];

   logic [PLAYERS-1:0] deb_a_q, deb_a_d;
   logic [PLAYERS-1:0] deb_b_q, deb_b_d;
   logic [PLAYERS-1:0] prev_a_q, prev_a_d;

   logic [PW-1:0] pos_q [PLAYERS];
   logic [PW-1:0] pos_d [PLAYERS];
   logic [HW-1:0] h_q   [PLAYERS];
   logic [HW-1:0] h_d   [PLAYERS];

   logic [PLAYERS-1:0] evt_q, evt_d;
   logic [PLAYERS-1:0] dir_q, dir_d;

   logic [PLAYERS*ROWS-1:0] pad_q, pad_d;

   // Shift raw lines into history; debounced level flips only on a full run.
   always_comb begin
      deb_a_d  = deb_a_q;
      deb_b_d  = deb_b_q;
      prev_a_d = deb_a_q;
      for (int i = 0; i < PLAYERS; i++) begin
         hist_a_d[i] = {hist_a_q[i][HIST_LEN-2:0], enc_a[i]};
         hist_b_d[i] = {hist_b_q[i][HIST_LEN-2:0], enc_b[i]};
         if (&hist_a_q[i]) begin
            deb_a_d[i] = 1'b1;
         end else if (~|hist_a_q[i]) begin
            deb_a_d[i] = 1'b0;
         end
         if (&hist_b_q[i]) begin
            deb_b_d[i] = 1'b1;
         end else if (~|hist_b_q[i]) begin
            deb_b_d[i] = 1'b0;
         end
      end
   end

   // Step on debounced A rise; apply with current height, then clamp.
   // A step only counts as an event if it moves pos beyond what the
   // height clamp alone would have produced.
   always_comb begin
      logic [HW-1:0] h;
      int mx;
      int cur;
      int clamp;
      int nxt;
      logic step;
      for (int i = 0; i < PLAYERS; i++) begin
         h     = width[i] ? HW'(PAD_H1) : HW'(PAD_H0);
         mx    = ROWS - int'(h);
         cur   = int'(pos_q[i]);
         clamp = (cur > mx) ? mx : cur;
         nxt   = clamp;
         step  = deb_a_q[i] & ~prev_a_q[i] & ~freeze;
         if (step) begin
            if (!deb_b_q[i]) begin
               nxt = cur + 1;
            end else begin
               nxt = (cur > 0) ? cur - 1 : 0;
            end
            if (nxt > mx) begin
               nxt = mx;
            end
         end
         pos_d[i] = PW'(nxt);
         h_d[i]   = h;
         evt_d[i] = (nxt != clamp);
         dir_d[i] = (nxt != clamp) ? ~deb_b_q[i] : dir_q[i];
      end
   end

   // Expand each registered position/height into a row bitmap.
   always_comb begin
      pad_d = '0;
      for (int i = 0; i < PLAYERS; i++) begin
         for (int r = 0; r < ROWS; r++) begin
            pad_d[i*ROWS+r] = (r >= int'(pos_q[i])) &&
                              (r < int'(pos_q[i]) + int'(h_q[i]));
         end
      end
   end

   // State registers for all channels.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < PLAYERS; i++) begin
            hist_a_q[i] <= '0;
            hist_b_q[i] <= '0;
            pos_q[i]    <= PW'(POS0);
            h_q[i]      <= HW'(PAD_H0);
         end
         deb_a_q  <= '0;
         deb_b_q  <= '0;
         prev_a_q <= '0;
         evt_q    <= '0;
         dir_q    <= '0;
         pad_q    <= {PLAYERS{RST_MASK}};
      end else begin
         for (int i = 0; i < PLAYERS; i++) begin
            hist_a_q[i] <= hist_a_d[i];
            hist_b_q[i] <= hist_b_d[i];
            pos_q[i]    <= pos_d[i];
            h_q[i]      <= h_d[i];
         end
         deb_a_q  <= deb_a_d;
         deb_b_q  <= deb_b_d;
         prev_a_q <= prev_a_d;
         evt_q    <= evt_d;
         dir_q    <= dir_d;
         pad_q    <= pad_d;
      end
   end

   assign paddles  = pad_q;
   assign step_evt = evt_q;
   assign step_dir = dir_q;

endmodule

// File: tb/tb_paddle_input_bank.sv
// tb_paddle_input_bank: scoreboard bench with a run-length debounce model
// and integer position model for paddle_input_bank.
module tb_paddle_input_bank;

   localparam int P  = 2;
   localparam int HL = 4;
   localparam int R  = 16;
   localparam int H0 = 3;
   localparam int H1 = 5;
   localparam int W  = P*R + 2*P;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [P-1:0] enc_a = '0;
   logic [P-1:0] enc_b = '0;
   logic [P-1:0] width = '0;
   logic freeze = 1'b0;
   logic [P*R-1:0] paddles;
   logic [P-1:0] step_evt;
   logic [P-1:0] step_dir;

   paddle_input_bank #(
      .PLAYERS(P), .HIST_LEN(HL), .ROWS(R), .PAD_H0(H0), .PAD_H1(H1)
   ) dut (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
      .width(width), .freeze(freeze), .paddles(paddles),
      .step_evt(step_evt), .step_dir(step_dir)
   );

   always #5 clk = ~clk;

   logic [W-1:0] sb[$];
   int total = 0;
   int passed = 0;
   int evc[P];

   // reference model state
   int m_pos[P];
   int m_h[P];
   int m_run_a[P];
   int m_run_b[P];
   bit m_val_a[P];
   bit m_val_b[P];
   bit m_deb_a[P];
   bit m_deb_b[P];
   bit m_prev[P];
   bit m_evt[P];
   bit m_dir[P];
   logic [R-1:0] m_pad[P];

   function automatic logic [R-1:0] mask(int p, int h);
      logic [R-1:0] m;
      m = '1;
      m = m >> (R - h);
      m = m << p;
      return m;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < P; i++) begin
         m_pos[i] = (R - H0) / 2;
         m_h[i] = H0;
         m_run_a[i] = HL; m_val_a[i] = 0;
         m_run_b[i] = HL; m_val_b[i] = 0;
         m_deb_a[i] = 0; m_deb_b[i] = 0; m_prev[i] = 0;
         m_evt[i] = 0; m_dir[i] = 0;
         m_pad[i] = mask(m_pos[i], H0);
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < P; i++) begin
         int h, mx, co, ws, t;
         bit up, step;
         logic [R-1:0] np;
         np = mask(m_pos[i], m_h[i]);
         h = width[i] ? H1 : H0;
         mx = R - h;
         co = (m_pos[i] > mx) ? mx : m_pos[i];
         ws = co;
         up = !m_deb_b[i];
         step = m_deb_a[i] && !m_prev[i] && !freeze;
         if (step) begin
            t = up ? m_pos[i] + 1 : m_pos[i] - 1;
            if (t < 0) t = 0;
            if (t > mx) t = mx;
            ws = t;
         end
         m_evt[i] = (ws != co);
         if (m_evt[i]) m_dir[i] = up;
         m_pos[i] = ws;
         m_h[i] = h;
         m_prev[i] = m_deb_a[i];
         if (m_run_a[i] >= HL) m_deb_a[i] = m_val_a[i];
         if (m_run_b[i] >= HL) m_deb_b[i] = m_val_b[i];
         if (enc_a[i] == m_val_a[i]) begin
            if (m_run_a[i] < HL) m_run_a[i]++;
         end else begin
            m_val_a[i] = enc_a[i]; m_run_a[i] = 1;
         end
         if (enc_b[i] == m_val_b[i]) begin
            if (m_run_b[i] < HL) m_run_b[i]++;
         end else begin
            m_val_b[i] = enc_b[i]; m_run_b[i] = 1;
         end
         m_pad[i] = np;
      end
   endtask

   task automatic push_exp();
      logic [P*R-1:0] pv;
      logic [P-1:0] ev, dv;
      for (int i = 0; i < P; i++) begin
         pv[i*R +: R] = m_pad[i];
         ev[i] = m_evt[i];
         dv[i] = m_dir[i];
      end
      sb.push_back({pv, ev, dv});
   endtask

   // called at a negedge; returns at the following negedge
   task automatic cyc(logic [P-1:0] a, logic [P-1:0] b,
                      logic [P-1:0] w, logic fr);
      enc_a = a; enc_b = b; width = w; freeze = fr;
      model_edge();
      push_exp();
      @(negedge clk);
   endtask

   task automatic hold(logic [P-1:0] a, logic [P-1:0] b,
                       logic [P-1:0] w, logic fr, int n);
      for (int k = 0; k < n; k++) cyc(a, b, w, fr);
   endtask

   // monitor: pop and compare after every active edge
   initial begin
      logic [W-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("cycle", 64'({paddles, step_evt, step_dir}), 64'(e));
         end
         for (int i = 0; i < P; i++) evc[i] += int'(step_evt[i]);
      end
   end

   initial begin
      logic [P-1:0] ra, rb, rw;
      int ta[P], tb[P];
      for (int i = 0; i < P; i++) evc[i] = 0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // 1: reset state
      hold(0, 0, 0, 0, 1);
      chk("reset_pad", 64'(paddles), 64'(32'h01C0_01C0));
      chk("reset_evt", 64'(step_evt), 64'(0));

      // 2: first increment step on P0
      for (int i = 0; i < P; i++) evc[i] = 0;
      hold(2'b01, 0, 0, 0, 5);
      chk("pre_step_evt", 64'(step_evt), 64'(0));
      hold(2'b01, 0, 0, 0, 1);
      chk("step_evt", 64'({step_evt, step_dir}), 64'(4'b0101));
      hold(2'b01, 0, 0, 0, 1);
      chk("first_step_pad", 64'(paddles), 64'(32'h01C0_0380));
      hold(0, 0, 0, 0, 6);

      // 3: saturate at top
      for (int k = 0; k < 20; k++) begin
         hold(2'b01, 0, 0, 0, 6);
         hold(0, 0, 0, 0, 6);
      end
      chk("sat_top", 64'(paddles[R-1:0]), 64'(16'hE000));
      chk("sat_evt_cnt", 64'(evc[0]), 64'(7));

      // 4: width rise clamps, then decrement to bottom
      evc[0] = 0;
      hold(0, 0, 2'b01, 0, 3);
      chk("clamp_pad", 64'(paddles[R-1:0]), 64'(16'hF800));
      chk("clamp_no_evt", 64'(evc[0]), 64'(0));
      hold(0, 2'b01, 2'b01, 0, 6);
      for (int k = 0; k < 15; k++) begin
         hold(2'b01, 2'b01, 2'b01, 0, 6);
         hold(0, 2'b01, 2'b01, 0, 6);
      end
      chk("sat_bottom", 64'(paddles[R-1:0]), 64'(16'h001F));
      chk("dir_down", 64'(step_dir[0]), 64'(0));

      // 5: short pulse and frozen detent on P1
      evc[1] = 0;
      hold(2'b10, 0, 2'b01, 0, 3);
      hold(0, 0, 2'b01, 0, 8);
      chk("short_pulse", 64'(paddles[2*R-1:R]), 64'(16'h01C0));
      hold(2'b10, 0, 2'b01, 1, 6);
      hold(0, 0, 2'b01, 1, 6);
      chk("freeze_pad", 64'(paddles[2*R-1:R]), 64'(16'h01C0));
      chk("freeze_evt", 64'(evc[1]), 64'(0));

      // 6: async reset mid-detent
      for (int k = 0; k < 2; k++) begin
         hold(2'b10, 0, 2'b01, 0, 6);
         hold(0, 0, 2'b01, 0, 6);
      end
      hold(2'b11, 0, 2'b01, 0, 3);
      reset = 1'b0;
      #1;
      chk("async_reset_pad", 64'(paddles), 64'(32'h01C0_01C0));
      chk("async_reset_evt", 64'(step_evt), 64'(0));
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      hold(2'b11, 0, 2'b01, 0, 5);
      chk("rel_no_evt", 64'(step_evt), 64'(0));
      hold(2'b11, 0, 2'b01, 0, 1);
      chk("rel_step", 64'({step_evt, step_dir}), 64'(4'b1111));
      hold(0, 0, 2'b01, 0, 6);

      // random phase
      ra = '0; rb = '0; rw = '0;
      for (int i = 0; i < P; i++) begin
         ta[i] = 0; tb[i] = 0;
      end
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < P; i++) begin
            if (ta[i] == 0) begin
               ra[i] = 1'($urandom_range(0, 1));
               ta[i] = $urandom_range(1, 9);
            end
            if (tb[i] == 0) begin
               rb[i] = 1'($urandom_range(0, 1));
               tb[i] = $urandom_range(1, 12);
            end
            ta[i]--; tb[i]--;
            if ($urandom_range(0, 99) < 3) rw[i] = ~rw[i];
         end
         cyc(ra, rb, rw, ($urandom_range(0, 99) < 8));
      end
      hold(0, 0, 0, 0, 2);
      chk("sb_drained", 64'(sb.size()), 64'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/paddle_input_bank.md
Name: paddle_input_bank

Overview:
Parametrised, N-player input front-end for the game core. Per player it debounces the two rotary-encoder lines, decodes quadrature steps, and keeps a saturating paddle position with a selectable paddle height. It emits a registered one-hot-run paddle bitmap per player, ready for the game and screen blocks. It replaces the hand-replicated debounce, rot_encoder and paddle chains, and adds multi-player, freeze and live height change with clamping.

Parameters:
PLAYERS, 2, number of independent player channels (1..8)
HIST_LEN, 16, debounce history length in clk samples (>=2)
ROWS, 16, paddle column height in rows (bitmap width per player, >=8)
PAD_H0, 3, paddle height when width[i]=0 (1..ROWS)
PAD_H1, 5, paddle height when width[i]=1 (PAD_H0..ROWS)

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (reset=0 resets all state immediately)
enc_a  input  PLAYERS  raw encoder A line, bit i = player i
enc_b  input  PLAYERS  raw encoder B line, bit i = player i
width  input  PLAYERS  paddle height select per player (0=PAD_H0, 1=PAD_H1)
freeze  input  1  when 1, decoded steps are discarded; positions hold
paddles  output  PLAYERS*ROWS  bitmap, slice [i*ROWS +: ROWS] = player i, bit r set = row r occupied
step_evt  output  PLAYERS  one-cycle pulse when player i's position changed due to a step
step_dir  output  PLAYERS  direction of the last applied step (1=increment, 0=decrement)

Behaviour:
- Per-channel pipeline, identical and independent for every player i. There is no cross-channel interaction except the shared freeze input.
- Debounce, per raw line:
  - hist <= {hist[HIST_LEN-2:0], raw} every cycle.
  - deb <= 1 if hist is all ones; deb <= 0 if hist is all zeros; otherwise deb holds.
  - Reset: hist=0, deb=0.
- Decoder:
  - prev_a <= deb_a every cycle.
  - A step occurs in a cycle where deb_a=1 and prev_a=0.
  - Direction is +1 if deb_b=0, -1 if deb_b=1.
  - A falling deb_a and any activity on B alone produce no step.
  - Reset: prev_a=0.
- Position:
  - pos is a register of width $clog2(ROWS) holding the index of the lowest occupied row.
  - H = width[i] ? PAD_H1 : PAD_H0; MAX = ROWS-H.
  - Reset: pos = (ROWS-PAD_H0)/2 (integer divide).
  - On a step with freeze=0: pos <= min(pos+1, MAX) or max(pos-1, 0).
  - Steps at a bound saturate silently: pos is unchanged and step_evt stays 0.
  - Every cycle, if pos > MAX for the current H (width rose), pos <= MAX.
  - A step and a width change in the same cycle: apply the step using the new H, then clamp to the new MAX. All in one cycle, no wrap.
  - freeze=1: steps are decoded but discarded; step_evt=0. Width clamping still applies.
- step_evt / step_dir:
  - Registered at the same edge as the pos update.
  - step_evt=1 for exactly one cycle only when pos actually changed due to a step. A clamp-only change gives step_evt=0.
  - step_dir updates only with step_evt.
  - Reset: step_evt=0, step_dir=0.
- Bitmap:
  - paddles slice <= bits [pos .. pos+H-1] set, all others 0.
  - Registered one cycle after pos, using the H of the cycle pos was computed in.
  - Reset value: bits [(ROWS-PAD_H0)/2 .. +PAD_H0-1] set in every slice.
- Latency for a raw A rise held stable, counting edges after the first sample:
  - hist all ones at edge HIST_LEN.
  - deb=1 at edge HIST_LEN+1.
  - pos and step_evt at edge HIST_LEN+2.
  - paddles at edge HIST_LEN+3.
- A raw pulse shorter than HIST_LEN cycles never changes deb.
- Reset asserted mid-operation returns all registers to their reset values asynchronously. After release, a raw A that is already high produces a step only after HIST_LEN+2 edges (deb rises from 0).

Test Plan:
(PLAYERS=2, HIST_LEN=4, ROWS=16, PAD_H0=3, PAD_H1=5 unless noted)
1. Release reset, idle inputs -> both slices = 16'h01C0 (pos 6), step_evt=0.
2. P0: enc_b=0, raise enc_a and hold -> at edge 6 pos=7 and step_evt[0] pulses once with step_dir[0]=1; at edge 7 slice0=16'h0380; slice1 unchanged.
3. P0: 20 increment detents (A high 6 cycles, low 6 cycles, B=0) -> saturates at slice0=16'hE000 (pos 13); step_evt fires exactly 7 times.
4. With slice0=16'hE000, set width[0]=1 -> pos clamps to 11, slice0=16'hF800, step_evt[0]=0. Then 15 decrements (B=1) -> slice0=16'h001F, no underflow.
5. P1: enc_a pulse high for 3 cycles only, then low -> no step, slice1 stays 16'h01C0. Then a full detent with freeze=1 -> slice1 still 16'h01C0, step_evt[1]=0.
6. Assert reset for 1 cycle mid-detent with both pos non-default -> slices immediately 16'h01C0. With enc_a still high at release, the step appears 6 edges after release.
